// File: rtl/banked_reg_file.sv
// Parametrised register bank with two combinational read ports, one write port,
// optional write-to-read bypass and a shadow bank with a sequenced save/restore engine.
module banked_reg_file #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 2,
   parameter int BYPASS = 1
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [ADDR_W-1:0] read1,
   input  logic [ADDR_W-1:0] read2,
   input  logic              isWrite,
   input  logic [ADDR_W-1:0] writeReg,
   input  logic [WIDTH-1:0]  writeData,
   input  logic              saveReq,
   input  logic              restoreReq,
   output logic [WIDTH-1:0]  reg1,
   output logic [WIDTH-1:0]  reg2,
   output logic [WIDTH-1:0]  reg3,
   output logic              busy,
   output logic              done
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};
   localparam logic [ADDR_W-1:0] ZERO_IDX = {ADDR_W{1'b0}};
   localparam logic BYP_EN = (BYPASS != 0);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SAVE    = 2'd1,
      RESTORE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              done_q, done_d;
   logic [WIDTH-1:0]  live_q   [DEPTH];
   logic [WIDTH-1:0]  live_d   [DEPTH];
   logic [WIDTH-1:0]  shadow_q [DEPTH];
   logic [WIDTH-1:0]  shadow_d [DEPTH];
   logic              accept_s;

   assign accept_s = isWrite && (state_q == IDLE) && !RESET;

   // State register: FSM, index counter, done pulse and both banks.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= IDLE;
         idx_q   <= ZERO_IDX;
         done_q  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            live_q[i]   <= {WIDTH{1'b0}};
            shadow_q[i] <= {WIDTH{1'b0}};
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
         for (int i = 0; i < DEPTH; i++) begin
            live_q[i]   <= live_d[i];
            shadow_q[i] <= shadow_d[i];
         end
      end
   end

   // Next-state logic; saveReq wins over restoreReq, requests while busy are ignored.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            idx_d = ZERO_IDX;
            if (saveReq) begin
               state_d = SAVE;
            end else if (restoreReq) begin
               state_d = RESTORE;
            end else begin
               state_d = IDLE;
            end
         end
         SAVE, RESTORE: begin
            idx_d = idx_q + ADDR_W'(1);
            if (idx_q == LAST_IDX) begin
               state_d = IDLE;
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = ZERO_IDX;
         end
      endcase
   end

   // Bank update and done generation: one entry copied per cycle while sequencing.
   always_comb begin
      done_d = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         live_d[i]   = live_q[i];
         shadow_d[i] = shadow_q[i];
      end
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               live_d[writeReg] = writeData;
            end else begin
               live_d[writeReg] = live_q[writeReg];
            end
         end
         SAVE: begin
            shadow_d[idx_q] = live_q[idx_q];
            done_d          = (idx_q == LAST_IDX);
         end
         RESTORE: begin
            live_d[idx_q] = shadow_q[idx_q];
            done_d        = (idx_q == LAST_IDX);
         end
         default: begin
            done_d = 1'b0;
         end
      endcase
   end

   // Read ports with optional same-cycle forwarding of an accepted write.
   always_comb begin
      if (BYP_EN && accept_s && (writeReg == read1)) begin
         reg1 = writeData;
      end else begin
         reg1 = live_q[read1];
      end
      if (BYP_EN && accept_s && (writeReg == read2)) begin
         reg2 = writeData;
      end else begin
         reg2 = live_q[read2];
      end
      if (BYP_EN && accept_s && (writeReg == ZERO_IDX)) begin
         reg3 = writeData;
      end else begin
         reg3 = live_q[0];
      end
   end

   assign busy = (state_q != IDLE);
   assign done = done_q;

endmodule

// File: tb/tb_banked_reg_file.sv
// Self-checking bench for banked_reg_file: bypass and non-bypass instances share stimulus.
module tb_banked_reg_file;

   logic       CLK = 1'b0;
   logic       RESET;
   logic [1:0] read1, read2, writeReg;
   logic       isWrite, saveReq, restoreReq;
   logic [7:0] writeData;
   logic [7:0] reg1_b, reg2_b, reg3_b, reg1_n, reg2_n, reg3_n;
   logic       busy_b, done_b, busy_n, done_n;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      string      name;
      logic [7:0] val;
   } exp_t;
   exp_t sb_q[$];

   typedef struct {
      logic       wr;
      logic [1:0] wreg;
      logic [7:0] wdata;
      logic [1:0] r1;
      logic [1:0] r2;
      logic [7:0] e1, e2, e3;
      logic [7:0] n1, n2, n3;
   } vec_t;
   vec_t vecs[5];

   banked_reg_file #(.WIDTH(8), .ADDR_W(2), .BYPASS(1)) dut (
      .CLK(CLK), .RESET(RESET), .read1(read1), .read2(read2), .isWrite(isWrite),
      .writeReg(writeReg), .writeData(writeData), .saveReq(saveReq), .restoreReq(restoreReq),
      .reg1(reg1_b), .reg2(reg2_b), .reg3(reg3_b), .busy(busy_b), .done(done_b));

   banked_reg_file #(.WIDTH(8), .ADDR_W(2), .BYPASS(0)) dut_nb (
      .CLK(CLK), .RESET(RESET), .read1(read1), .read2(read2), .isWrite(isWrite),
      .writeReg(writeReg), .writeData(writeData), .saveReq(saveReq), .restoreReq(restoreReq),
      .reg1(reg1_n), .reg2(reg2_n), .reg3(reg3_n), .busy(busy_n), .done(done_n));

   always #5 CLK = ~CLK;

   task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic sb_push(input string nm, input logic [7:0] v);
      exp_t e;
      e.name = nm;
      e.val  = v;
      sb_q.push_back(e);
   endtask

   task automatic sb_pop_check(input logic [7:0] act);
      exp_t e;
      if (sb_q.size() == 0) begin
         check("scoreboard_empty", 8'h01, 8'h00);
      end else begin
         e = sb_q.pop_front();
         check(e.name, act, e.val);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
      isWrite = 1'b1; writeReg = a; writeData = d;
      step();
      isWrite = 1'b0;
   endtask

   task automatic read_all(input string nm, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3);
      logic [7:0] ev [4];
      ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
      for (int i = 0; i < 4; i++) begin
         read1 = 2'(i);
         read2 = 2'(3 - i);
         #1;
         check($sformatf("%s_r%0d_p1", nm, i), reg1_b, ev[i]);
         check($sformatf("%s_r%0d_p2", nm, 3 - i), reg2_b, ev[3 - i]);
      end
      check({nm, "_reg3"}, reg3_b, e0);
   endtask

   // Run one save/restore after its request was sampled; measure busy length and done pulse.
   task automatic run_seq(input string nm, input bit drop_wr, input logic [7:0] r3_exp,
                          input bit extra_req);
      int bc;
      int dc;
      bit seen;
      bc = 0; seen = 1'b0;
      for (int k = 0; k < 16 && !seen; k++) begin
         @(negedge CLK);
         if (done_b) begin
            seen = 1'b1;
            check({nm, "_busy_in_done"}, {7'd0, busy_b}, 8'd0);
         end else if (busy_b) begin
            bc++;
            if (drop_wr && bc == 1) begin
               isWrite = 1'b1; writeReg = 2'd3; writeData = 8'h99; read1 = 2'd3;
               #1;
               check({nm, "_no_bypass_busy"}, reg1_b, r3_exp);
            end
            if (extra_req && bc == 2) begin
               restoreReq = 1'b1;
            end
         end
         @(posedge CLK);
         #1;
         isWrite = 1'b0; restoreReq = 1'b0;
      end
      check({nm, "_done_seen"}, {7'd0, seen}, 8'd1);
      check({nm, "_busy_cycles"}, 8'(bc), 8'd4);
      dc = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge CLK);
         if (done_b) dc++;
      end
      check({nm, "_done_width"}, 8'(dc), 8'd0);
      check({nm, "_idle_after"}, {7'd0, busy_b}, 8'd0);
   endtask

   initial begin
      logic [7:0] act [6];
      int dc;

      vecs[0] = '{1'b1, 2'd2, 8'hA5, 2'd2, 2'd0, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      vecs[1] = '{1'b1, 2'd0, 8'h3C, 2'd2, 2'd0, 8'hA5, 8'h3C, 8'h3C, 8'hA5, 8'h00, 8'h00};
      vecs[2] = '{1'b0, 2'd0, 8'h00, 2'd0, 2'd2, 8'h3C, 8'hA5, 8'h3C, 8'h3C, 8'hA5, 8'h3C};
      vecs[3] = '{1'b1, 2'd1, 8'h77, 2'd1, 2'd1, 8'h77, 8'h77, 8'h3C, 8'h00, 8'h00, 8'h3C};
      vecs[4] = '{1'b0, 2'd0, 8'h00, 2'd1, 2'd1, 8'h77, 8'h77, 8'h3C, 8'h77, 8'h77, 8'h3C};

      RESET = 1'b1; isWrite = 1'b0; writeReg = 2'd0; writeData = 8'h00;
      read1 = 2'd1; read2 = 2'd2; saveReq = 1'b0; restoreReq = 1'b0;
      #12;
      check("rst_reg1", reg1_b, 8'h00);
      check("rst_reg3", reg3_b, 8'h00);
      check("rst_busy_done", {6'd0, busy_b, done_b}, 8'h00);
      @(negedge CLK);
      RESET = 1'b0;
      step();

      // Table vectors: drive after the edge, compare before the next edge.
      foreach (vecs[i]) begin
         isWrite = vecs[i].wr; writeReg = vecs[i].wreg; writeData = vecs[i].wdata;
         read1 = vecs[i].r1; read2 = vecs[i].r2;
         sb_push($sformatf("v%0d_byp_reg1", i), vecs[i].e1);
         sb_push($sformatf("v%0d_byp_reg2", i), vecs[i].e2);
         sb_push($sformatf("v%0d_byp_reg3", i), vecs[i].e3);
         sb_push($sformatf("v%0d_nb_reg1", i), vecs[i].n1);
         sb_push($sformatf("v%0d_nb_reg2", i), vecs[i].n2);
         sb_push($sformatf("v%0d_nb_reg3", i), vecs[i].n3);
         @(negedge CLK);
         act[0] = reg1_b; act[1] = reg2_b; act[2] = reg3_b;
         act[3] = reg1_n; act[4] = reg2_n; act[5] = reg3_n;
         for (int j = 0; j < 6; j++) sb_pop_check(act[j]);
         step();
      end
      isWrite = 1'b0;

      // Asynchronous reset in the middle of a cycle clears reads immediately.
      read1 = 2'd1; read2 = 2'd2;
      #2;
      RESET = 1'b1;
      #1;
      check("async_rst_reg1", reg1_b, 8'h00);
      check("async_rst_reg2", reg2_b, 8'h00);
      check("async_rst_reg3", reg3_b, 8'h00);
      @(negedge CLK);
      RESET = 1'b0;
      step();

      // Save with restoreReq also high: SAVE must win, write during busy dropped.
      write_reg(2'd0, 8'h11);
      write_reg(2'd1, 8'h22);
      write_reg(2'd2, 8'h33);
      write_reg(2'd3, 8'h44);
      saveReq = 1'b1; restoreReq = 1'b1;
      step();
      saveReq = 1'b0; restoreReq = 1'b0;
      run_seq("save1", 1'b1, 8'h44, 1'b0);
      read_all("after_save", 8'h11, 8'h22, 8'h33, 8'h44);

      for (int i = 0; i < 4; i++) write_reg(2'(i), 8'hFF);
      read_all("overwritten", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
      restoreReq = 1'b1;
      step();
      restoreReq = 1'b0;
      run_seq("restore1", 1'b0, 8'h00, 1'b1);
      read_all("after_restore", 8'h11, 8'h22, 8'h33, 8'h44);

      // A write in the same cycle as saveReq is captured by the save.
      isWrite = 1'b1; writeReg = 2'd1; writeData = 8'h5A; saveReq = 1'b1;
      step();
      isWrite = 1'b0; saveReq = 1'b0;
      run_seq("save_wr", 1'b0, 8'h00, 1'b0);
      write_reg(2'd1, 8'h00);
      restoreReq = 1'b1;
      step();
      restoreReq = 1'b0;
      run_seq("restore_wr", 1'b0, 8'h00, 1'b0);
      read_all("shadow_wr", 8'h11, 8'h5A, 8'h33, 8'h44);

      // Reset during the second cycle of a restore aborts without a done pulse.
      restoreReq = 1'b1;
      step();
      restoreReq = 1'b0;
      @(negedge CLK);
      step();
      @(negedge CLK);
      check("mid_busy_before_rst", {7'd0, busy_b}, 8'd1);
      #1;
      RESET = 1'b1;
      read1 = 2'd1; read2 = 2'd2;
      #1;
      check("mid_rst_busy", {7'd0, busy_b}, 8'd0);
      check("mid_rst_reg1", reg1_b, 8'h00);
      check("mid_rst_reg2", reg2_b, 8'h00);
      check("mid_rst_reg3", reg3_b, 8'h00);
      step();
      @(negedge CLK);
      RESET = 1'b0;
      dc = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge CLK);
         if (done_b) dc++;
      end
      check("mid_rst_no_done", 8'(dc), 8'd0);
      step();
      saveReq = 1'b1;
      step();
      saveReq = 1'b0;
      run_seq("save_zero", 1'b0, 8'h00, 1'b0);
      write_reg(2'd2, 8'hC3);
      restoreReq = 1'b1;
      step();
      restoreReq = 1'b0;
      run_seq("restore_zero", 1'b0, 8'h00, 1'b0);
      read_all("zeros", 8'h00, 8'h00, 8'h00, 8'h00);
      check("nb_restore_zero_r2", reg2_n, reg2_b);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, limit 200000 time units");
      $fatal(1);
   end

endmodule

// File: doc/banked_reg_file.md
Name: banked_reg_file

Overview:
- Parametrised successor to the 4x8 scratch register file.
- Provides a WIDTH-bit, 2**ADDR_W-entry architectural register bank:
  - two combinational read ports, one clocked write port, and a dedicated always-on register-0 output;
  - optional same-cycle write-to-read bypass;
  - a shadow bank with a sequenced save/restore engine that copies all entries one per cycle.
- Sits in the single-cycle datapath between decode and ALU. The shadow bank serves interrupt/context swap under control-unit supervision.

Parameters:
- WIDTH, 8, data width of every register in bits.
- ADDR_W, 2, register address width; DEPTH = 2**ADDR_W entries.
- BYPASS, 1, when 1 an accepted write is forwarded combinationally to matching read ports in the same cycle; when 0 there is no forwarding.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RESET  input  1  asynchronous, active-high reset.
- read1  input  ADDR_W  read port 1 address.
- read2  input  ADDR_W  read port 2 address.
- isWrite  input  1  write request.
- writeReg  input  ADDR_W  write address.
- writeData  input  WIDTH  write data.
- saveReq  input  1  start copy of live bank to shadow bank.
- restoreReq  input  1  start copy of shadow bank to live bank.
- reg1  output  WIDTH  read port 1 data.
- reg2  output  WIDTH  read port 2 data.
- reg3  output  WIDTH  always entry 0 of the live bank.
- busy  output  1  save/restore sequence in progress.
- done  output  1  one-cycle pulse when a sequence completes.

Behaviour:
- Clock and reset: one clock, CLK. Reset RESET is asynchronous and active-high.
- Reset values:
  - live bank and shadow bank entries = 0; FSM = IDLE; index counter = 0.
  - busy = 0, done = 0; reg1/reg2/reg3 = 0. No write is accepted while RESET is high, so there is no bypass.
- Reset mid-sequence aborts immediately: FSM to IDLE, both banks cleared, no done pulse.
- Reads:
  - reg1 = live[read1], reg2 = live[read2], reg3 = live[0]; combinational, zero latency.
  - read1 == read2 is legal; both return the same value.
- Write acceptance: accept = isWrite && state == IDLE && !RESET. An accepted write updates live[writeReg] at the next posedge.
- Bypass (BYPASS=1):
  - while accept is high, any read port whose address equals writeReg (reg3: address 0) returns writeData in the same cycle.
  - BYPASS=0: the new value appears only after the edge.
- isWrite while busy is silently dropped; no bypass is applied. The control unit must stall.
- FSM states IDLE, SAVE, RESTORE:
  - IDLE: if saveReq, go to SAVE at the next edge with idx=0. Else if restoreReq, go to RESTORE with idx=0. saveReq has priority when both are high. An accepted write in the same cycle as saveReq lands before the copy begins, so it is saved.
  - SAVE: each edge, shadow[idx] <= live[idx], idx++. On the edge copying idx=DEPTH-1: idx wraps to 0, state goes to IDLE, done goes to 1.
  - RESTORE: identical sequencing with live[idx] <= shadow[idx]. Read ports reflect progressively restored entries during the sequence.
  - saveReq/restoreReq while busy are ignored, not queued.
- Timing for a request sampled at edge T:
  - busy = 1 from after T through edge T+DEPTH, i.e. exactly DEPTH cycles.
  - copies occur on edges T+1..T+DEPTH.
  - done = 1 for the single cycle after T+DEPTH; busy = 0 in that cycle.
  - a new request may be sampled in the done cycle.
- idx is ADDR_W bits and wraps naturally. No arithmetic is performed on data; values are stored unmodified at full WIDTH.

Test Plan:
- Reset/write/read: assert RESET async mid-cycle -> reg1/reg2/reg3 = 0 immediately. Write 0xA5 to r2, then read1=2 -> reg1 = 0xA5 after the edge. Write 0x3C to r0 -> reg3 = 0x3C.
- Bypass: BYPASS=1, isWrite=1, writeReg=1, writeData=0x77, read1=read2=1 -> reg1 = reg2 = 0x77 in the same cycle, before the edge. BYPASS=0 -> old value until the edge.
- Save/restore round trip (DEPTH=4):
  - load r0..r3 = 0x11,0x22,0x33,0x44 and pulse saveReq -> busy high 4 cycles, done pulse 1 cycle.
  - overwrite all entries with 0xFF, then pulse restoreReq -> after done, r0..r3 read 0x11..0x44.
- Writes during busy: during SAVE assert isWrite r3 = 0x99 -> write dropped, no bypass. After done, r3 still holds its prior value, and the shadow holds the prior value.
- Simultaneous events:
  - saveReq and restoreReq high together in IDLE -> SAVE runs.
  - saveReq together with a write of 0x5A to r1 -> shadow r1 = 0x5A.
  - restoreReq pulsed while busy -> ignored, no second done.
- Reset mid-sequence: RESET at cycle 2 of RESTORE -> busy = 0, done never pulses, all reads 0, and a subsequent save/restore of zeros completes normally.
